// File: rtl/float_operand_entry_pkg.sv
// Shared types and constants for the operator-entry controller that sits
// between the input debouncer and the float ALU.
package float_entry_pkg;

  // Controller states; encoding is visible on state_out.
  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_ENTER_B = 2'd1,
    ST_WAIT    = 2'd2,
    ST_SHOW    = 2'd3
  } state_t;

  // Bit positions inside button_pluse.
  localparam int BTN_LOAD  = 0;
  localparam int BTN_NEXT  = 1;
  localparam int BTN_EXEC  = 2;
  localparam int BTN_CLEAR = 3;

  // Quiet NaN shown when the ALU never answers.
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // ALU op codes taken from SW_OK[1:0] at EXEC.
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Shift one switch byte into the low end of an operand word.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                input logic [7:0]  data);
    return {word[23:0], data};
  endfunction

endpackage

// File: rtl/float_operand_entry_alu_wait_timer.sv
// Cycle counter that bounds how long the controller waits for the ALU.
// It saturates at TIMEOUT_CYCLES-1 and flags expired while sitting there.
module alu_wait_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_r;

  // Count enabled cycles, holding at LAST so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {TW{1'b0}};
    end else if (clear) begin
      count_r <= {TW{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/float_operand_entry.sv
// Operator-entry controller: builds two IEEE-754 operands a byte at a time
// from the switches, launches the float ALU, and holds its result for the
// display. A result can be chained back in as operand A.
module float_operand_entry
  import float_entry_pkg::*;
#(
  parameter int BYTES_PER_OP   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  button_pluse,
  input  logic [7:0]  SW_OK,
  input  logic        alu_ready,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  output logic [31:0] disp_value,
  output logic [2:0]  byte_cnt,
  output logic [1:0]  state_out,
  output logic        err
);

  localparam logic [2:0] CNT_FULL = 3'(BYTES_PER_OP);

  state_t      state_r;
  logic [31:0] operand_a_r;
  logic [31:0] operand_b_r;
  logic [31:0] result_r;
  logic [31:0] disp_value_r;
  logic [1:0]  alu_op_r;
  logic        alu_start_r;
  logic [2:0]  byte_cnt_r;
  logic        err_r;

  // Only the highest-priority pulse survives: CLEAR > EXEC > NEXT > LOAD.
  logic btn_clear_s;
  logic btn_exec_s;
  logic btn_next_s;
  logic btn_load_s;

  assign btn_clear_s = button_pluse[BTN_CLEAR];
  assign btn_exec_s  = button_pluse[BTN_EXEC] & ~button_pluse[BTN_CLEAR];
  assign btn_next_s  = button_pluse[BTN_NEXT] & ~button_pluse[BTN_EXEC]
                     & ~button_pluse[BTN_CLEAR];
  assign btn_load_s  = button_pluse[BTN_LOAD] & ~button_pluse[BTN_NEXT]
                     & ~button_pluse[BTN_EXEC] & ~button_pluse[BTN_CLEAR];

  // The timer is held at zero outside WAIT, so it starts fresh on every EXEC.
  logic timer_clear_s;
  logic timer_enable_s;
  logic timer_expired_s;

  assign timer_clear_s  = (state_r != ST_WAIT);
  assign timer_enable_s = (state_r == ST_WAIT);

  alu_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear_s),
    .enable (timer_enable_s),
    .expired(timer_expired_s)
  );

  // Entry FSM; disp_value is updated alongside whichever register it mirrors
  // so it always shows the value belonging to the next state.
  always_ff @(posedge clk) begin
    alu_start_r <= 1'b0;
    if (rst || btn_clear_s) begin
      state_r      <= ST_ENTER_A;
      operand_a_r  <= 32'h0000_0000;
      operand_b_r  <= 32'h0000_0000;
      result_r     <= 32'h0000_0000;
      disp_value_r <= 32'h0000_0000;
      alu_op_r     <= 2'd0;
      alu_start_r  <= 1'b0;
      byte_cnt_r   <= 3'd0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_ENTER_A: begin
          if (btn_next_s) begin
            state_r      <= ST_ENTER_B;
            operand_b_r  <= 32'h0000_0000;
            disp_value_r <= 32'h0000_0000;
            byte_cnt_r   <= 3'd0;
          end else if (btn_load_s) begin
            if (byte_cnt_r < CNT_FULL) begin
              operand_a_r  <= shift_in_byte(operand_a_r, SW_OK);
              disp_value_r <= shift_in_byte(operand_a_r, SW_OK);
              byte_cnt_r   <= byte_cnt_r + 3'd1;
            end else begin
              err_r <= 1'b1;
            end
          end else begin
            state_r <= ST_ENTER_A;
          end
        end
        ST_ENTER_B: begin
          if (btn_exec_s) begin
            if (alu_ready) begin
              alu_op_r    <= SW_OK[1:0];
              alu_start_r <= 1'b1;
              state_r     <= ST_WAIT;
            end else begin
              state_r <= ST_ENTER_B;
            end
          end else if (btn_load_s) begin
            if (byte_cnt_r < CNT_FULL) begin
              operand_b_r  <= shift_in_byte(operand_b_r, SW_OK);
              disp_value_r <= shift_in_byte(operand_b_r, SW_OK);
              byte_cnt_r   <= byte_cnt_r + 3'd1;
            end else begin
              err_r <= 1'b1;
            end
          end else begin
            state_r <= ST_ENTER_B;
          end
        end
        ST_WAIT: begin
          if (alu_done) begin
            result_r     <= alu_result;
            disp_value_r <= alu_result;
            state_r      <= ST_SHOW;
          end else if (timer_expired_s) begin
            result_r     <= QNAN;
            disp_value_r <= QNAN;
            err_r        <= 1'b1;
            state_r      <= ST_SHOW;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_SHOW: begin
          if (btn_next_s) begin
            operand_a_r  <= result_r;
            disp_value_r <= result_r;
            byte_cnt_r   <= CNT_FULL;
            state_r      <= ST_ENTER_A;
          end else if (btn_load_s) begin
            operand_a_r  <= {24'h00_0000, SW_OK};
            disp_value_r <= {24'h00_0000, SW_OK};
            byte_cnt_r   <= 3'd1;
            state_r      <= ST_ENTER_A;
          end else begin
            state_r <= ST_SHOW;
          end
        end
        default: begin
          state_r <= ST_ENTER_A;
        end
      endcase
    end
  end

  assign operand_a  = operand_a_r;
  assign operand_b  = operand_b_r;
  assign alu_op     = alu_op_r;
  assign alu_start  = alu_start_r;
  assign disp_value = disp_value_r;
  assign byte_cnt   = byte_cnt_r;
  assign state_out  = state_r;
  assign err        = err_r;

endmodule
